// File: rtl/sincos_lut_pipe_if.sv
// Request/result handshake bundle between an angle source and sincos_lut_pipe.
interface sincos_lut_pipe_if #(
  parameter int ANGLE_W = 10,
  parameter int OUT_W   = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic [ANGLE_W-1:0]        angle;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   sin_value;
  logic signed [OUT_W-1:0]   cos_value;
  logic                      out_err;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, sin_value, cos_value, out_err
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, sin_value, cos_value, out_err
  );
endinterface

// File: rtl/sincos_lut_pipe.sv
// Quarter-wave LUT sin/cos generator: integer degrees in, signed Q(FRAC_W) sin and cos out.
// 3-cycle latency, 1 result/cycle; the whole pipe freezes while a held result is not taken.
module sincos_lut_pipe #(
  parameter int ANGLE_W = 10,
  parameter int FRAC_W  = 8,
  parameter int OUT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  sincos_lut_pipe_if.slave bus
);
  localparam int AW = ANGLE_W + 1;
  localparam int MW = FRAC_W + 1;
  localparam logic [AW-1:0] D90  = AW'(90);
  localparam logic [AW-1:0] D180 = AW'(180);
  localparam logic [AW-1:0] D270 = AW'(270);
  localparam logic [AW-1:0] D360 = AW'(360);

  // round(sin(k deg) * 256), k = 0..90; held inline so the block needs no data file.
  localparam logic [8:0] SIN_Q8 [0:90] = '{
    9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
    9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
    9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
    9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
    9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
    9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
    9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
    9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
    9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
    9'd256
  };

  // Returns {negative, rom_index} for an angle already reduced to 0..359.
  function automatic logic [7:0] fold(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    if (a < D90)       t = a;
    else if (a < D180) t = D180 - a;
    else if (a < D270) t = a - D180;
    else               t = D360 - a;
    return {(a >= D180), 7'(t)};
  endfunction

  function automatic logic [MW-1:0] rom(input logic [6:0] i);
    return (i <= 7'd90) ? MW'(SIN_Q8[i]) : '0;
  endfunction

  function automatic logic [OUT_W-1:0] apply_sign(input logic [MW-1:0] m, input logic neg);
    logic [OUT_W-1:0] z;
    z = OUT_W'(m);
    return neg ? (~z + OUT_W'(1)) : z;
  endfunction

  logic          en;
  logic [AW-1:0] a_ext, c_sum, c_ang;
  logic [7:0]    fs, fc;

  assign en           = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    a_ext = {1'b0, bus.angle};
    c_sum = a_ext + D90;
    c_ang = (c_sum >= D360) ? (c_sum - D360) : c_sum;
    fs    = fold(a_ext);
    fc    = fold(c_ang);
  end

  logic          v1, err1, neg_s1, neg_c1;
  logic [6:0]    idx_s1, idx_c1;
  logic          v2, err2, neg_s2, neg_c2;
  logic [MW-1:0] mag_s2, mag_c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1            <= 1'b0;
      err1          <= 1'b0;
      neg_s1        <= 1'b0;
      neg_c1        <= 1'b0;
      idx_s1        <= '0;
      idx_c1        <= '0;
      v2            <= 1'b0;
      err2          <= 1'b0;
      neg_s2        <= 1'b0;
      neg_c2        <= 1'b0;
      mag_s2        <= '0;
      mag_c2        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.sin_value <= '0;
      bus.cos_value <= '0;
    end else if (en) begin
      v1            <= bus.in_valid;
      err1          <= (a_ext >= D360);
      {neg_s1, idx_s1} <= fs;
      {neg_c1, idx_c1} <= fc;
      v2            <= v1;
      err2          <= err1;
      neg_s2        <= neg_s1;
      neg_c2        <= neg_c1;
      mag_s2        <= rom(idx_s1);
      mag_c2        <= rom(idx_c1);
      bus.out_valid <= v2;
      bus.out_err   <= err2;
      bus.sin_value <= err2 ? '0 : apply_sign(mag_s2, neg_s2);
      bus.cos_value <= err2 ? '0 : apply_sign(mag_c2, neg_c2);
    end
  end
endmodule
